// File: rtl/lieat_exu_dcache_arb_if.sv
// ----------------------------------------------------------------------------
// lieat_exu_dcache_arb_if
// Bundle of every handshake bus around the dcache arbiter.
//   lsu_req_* / lsu_rsp_* : LSU request (with fence.i flag) and response
//   vpu_req_* / vpu_rsp_* : VPU request and response
//   mem_req_* / mem_rsp_* : single dcache request/response port
// Modports:
//   slave  : arbiter side (answers LSU/VPU, drives the dcache request)
//   master : environment side (LSU, VPU and dcache models)
// Handshake rule shared by every channel: a transfer happens on a rising clock
// edge where valid and ready are both high; valid never waits for ready.
// ----------------------------------------------------------------------------
interface lieat_exu_dcache_arb_if #(
  parameter int XLEN = 32
);
  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic            lsu_req_ren;
  logic            lsu_req_wen;
  logic            lsu_req_fencei;
  logic [XLEN-1:0] lsu_req_addr;
  logic [XLEN-1:0] lsu_req_wdata;
  logic [2:0]      lsu_req_flag;
  logic            lsu_rsp_valid;
  logic            lsu_rsp_ready;
  logic            lsu_rsp_fencei_over;
  logic [XLEN-1:0] lsu_rsp_rdata;

  logic            vpu_req_valid;
  logic            vpu_req_ready;
  logic            vpu_req_ren;
  logic            vpu_req_wen;
  logic [XLEN-1:0] vpu_req_addr;
  logic [XLEN-1:0] vpu_req_wdata;
  logic [2:0]      vpu_req_flag;
  logic            vpu_rsp_valid;
  logic            vpu_rsp_ready;
  logic [XLEN-1:0] vpu_rsp_rdata;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_ren;
  logic            mem_req_wen;
  logic            mem_req_fencei;
  logic [XLEN-1:0] mem_req_addr;
  logic [2:0]      mem_req_flag;
  logic [XLEN-1:0] mem_req_wdata;
  logic            mem_rsp_valid;
  logic            mem_rsp_ready;
  logic            mem_rsp_fencei_over;
  logic [XLEN-1:0] mem_rsp_rdata;

  modport slave (
    input  lsu_req_valid, lsu_req_ren, lsu_req_wen, lsu_req_fencei,
    input  lsu_req_addr, lsu_req_wdata, lsu_req_flag, lsu_rsp_ready,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_fencei_over, lsu_rsp_rdata,
    input  vpu_req_valid, vpu_req_ren, vpu_req_wen,
    input  vpu_req_addr, vpu_req_wdata, vpu_req_flag, vpu_rsp_ready,
    output vpu_req_ready, vpu_rsp_valid, vpu_rsp_rdata,
    output mem_req_valid, mem_req_ren, mem_req_wen, mem_req_fencei,
    output mem_req_addr, mem_req_flag, mem_req_wdata, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_fencei_over, mem_rsp_rdata
  );

  modport master (
    output lsu_req_valid, lsu_req_ren, lsu_req_wen, lsu_req_fencei,
    output lsu_req_addr, lsu_req_wdata, lsu_req_flag, lsu_rsp_ready,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_fencei_over, lsu_rsp_rdata,
    output vpu_req_valid, vpu_req_ren, vpu_req_wen,
    output vpu_req_addr, vpu_req_wdata, vpu_req_flag, vpu_rsp_ready,
    input  vpu_req_ready, vpu_rsp_valid, vpu_rsp_rdata,
    input  mem_req_valid, mem_req_ren, mem_req_wen, mem_req_fencei,
    input  mem_req_addr, mem_req_flag, mem_req_wdata, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_fencei_over, mem_rsp_rdata
  );
endinterface

// File: rtl/lieat_exu_dcache_arb.sv
// ----------------------------------------------------------------------------
// lieat_exu_dcache_arb
// Shares one dcache port between the LSU and the VPU with at most one
// outstanding transaction. Requests are granted combinationally in IDLE, the
// response is steered back to the owner, and a pipeline flush drops the
// outstanding response (consumed immediately or drained later).
// Ports:
//   clock       : sole clock, rising edge
//   reset       : asynchronous, active-low reset
//   flush_req   : pipeline flush from the commit unit
//   bus         : LSU / VPU / dcache handshake buses (slave modport)
//   arb_o_busy  : high whenever the FSM is not IDLE
//   o_dbg_state : current FSM state, for observation
// Configuration macro:
//   LIEAT_DCACHE_ARB_RR_EN : round-robin on simultaneous requests; when
//                            undefined the LSU always wins and no pointer
//                            register exists.
// ----------------------------------------------------------------------------
module lieat_exu_dcache_arb #(
  parameter int XLEN = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_req,
  lieat_exu_dcache_arb_if.slave bus,
  output logic                  arb_o_busy,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_LSU   = 3'd1,
    WAIT_VPU   = 3'd2,
    WAIT_FENCE = 3'd3,
    DRAIN      = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            w_grant_vpu;
  logic            w_sel_valid;
  logic            w_req_hs;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;

  // Grant selection. With no request pending the LSU is nominally granted,
  // which is harmless because mem_req_valid follows the (low) LSU valid.
`ifdef LIEAT_DCACHE_ARB_RR_EN
  // 1 = VPU is favoured on the next simultaneous request.
  logic r_rr_vpu;

  assign w_grant_vpu = bus.vpu_req_valid & (~bus.lsu_req_valid | r_rr_vpu);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_vpu <= 1'b0;
    end else if (w_req_hs) begin
      r_rr_vpu <= ~w_grant_vpu;
    end
  end
`else
  assign w_grant_vpu = bus.vpu_req_valid & ~bus.lsu_req_valid;
`endif

  assign w_sel_valid = w_grant_vpu ? bus.vpu_req_valid : bus.lsu_req_valid;
  assign w_req_hs    = (r_state == IDLE) & ~flush_req & w_sel_valid & bus.mem_req_ready;

  // Request fields are steered from the granted requester at all times; only
  // mem_req_valid qualifies them.
  assign w_addr             = w_grant_vpu ? bus.vpu_req_addr  : bus.lsu_req_addr;
  assign w_wdata            = w_grant_vpu ? bus.vpu_req_wdata : bus.lsu_req_wdata;
  assign bus.mem_req_addr   = w_addr;
  assign bus.mem_req_wdata  = w_wdata;
  assign bus.mem_req_ren    = w_grant_vpu ? bus.vpu_req_ren  : bus.lsu_req_ren;
  assign bus.mem_req_wen    = w_grant_vpu ? bus.vpu_req_wen  : bus.lsu_req_wen;
  assign bus.mem_req_flag   = w_grant_vpu ? bus.vpu_req_flag : bus.lsu_req_flag;
  assign bus.mem_req_fencei = ~w_grant_vpu & bus.lsu_req_fencei;

  // Read data is passed straight through; the valids decide who sees it.
  assign bus.lsu_rsp_rdata = bus.mem_rsp_rdata;
  assign bus.vpu_rsp_rdata = bus.mem_rsp_rdata;

  assign arb_o_busy  = (r_state != IDLE);
  assign o_dbg_state = r_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state            = r_state;
    bus.mem_req_valid       = 1'b0;
    bus.lsu_req_ready       = 1'b0;
    bus.vpu_req_ready       = 1'b0;
    bus.lsu_rsp_valid       = 1'b0;
    bus.vpu_rsp_valid       = 1'b0;
    bus.lsu_rsp_fencei_over = 1'b0;
    bus.mem_rsp_ready       = 1'b0;

    case (r_state)
      IDLE: begin
        // A flush blocks new requests for the cycle it is asserted.
        if (!flush_req) begin
          bus.mem_req_valid = w_sel_valid;
          bus.lsu_req_ready = ~w_grant_vpu & bus.mem_req_ready;
          bus.vpu_req_ready =  w_grant_vpu & bus.mem_req_ready;
          if (w_req_hs) begin
            if (w_grant_vpu)             w_next_state = WAIT_VPU;
            else if (bus.lsu_req_fencei) w_next_state = WAIT_FENCE;
            else                         w_next_state = WAIT_LSU;
          end
        end
      end

      WAIT_LSU, WAIT_VPU: begin
        if (flush_req) begin
          // Flush beats the response: swallow it now or drain it later.
          bus.mem_rsp_ready = 1'b1;
          w_next_state      = bus.mem_rsp_valid ? IDLE : DRAIN;
        end else if (r_state == WAIT_LSU) begin
          bus.lsu_rsp_valid = bus.mem_rsp_valid;
          bus.mem_rsp_ready = bus.lsu_rsp_ready;
          if (bus.mem_rsp_valid && bus.lsu_rsp_ready) w_next_state = IDLE;
        end else begin
          bus.vpu_rsp_valid = bus.mem_rsp_valid;
          bus.mem_rsp_ready = bus.vpu_rsp_ready;
          if (bus.mem_rsp_valid && bus.vpu_rsp_ready) w_next_state = IDLE;
        end
      end

      WAIT_FENCE: begin
        // fence.i cannot be cancelled; it ends on the dcache's one-cycle pulse.
        bus.lsu_rsp_fencei_over = bus.mem_rsp_fencei_over;
        if (bus.mem_rsp_fencei_over) w_next_state = IDLE;
      end

      DRAIN: begin
        bus.mem_rsp_ready = 1'b1;
        if (bus.mem_rsp_valid) w_next_state = IDLE;
      end

      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lieat_exu_dcache_arb.sv
module tb_lieat_exu_dcache_arb;

  logic       clock;
  logic       reset;
  logic       flush_req;
  logic       arb_o_busy;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int fence_cnt = 0;

  logic [31:0] exp_lsu_q[$];
  logic [31:0] exp_vpu_q[$];

  lieat_exu_dcache_arb_if #(.XLEN(32)) bus ();

  lieat_exu_dcache_arb #(.XLEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush_req   (flush_req),
    .bus         (bus),
    .arb_o_busy  (arb_o_busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (bus.lsu_rsp_valid && bus.lsu_rsp_ready) begin
        if (exp_lsu_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL lsu_rsp_unexpected: got 0x%0h expected no response", bus.lsu_rsp_rdata);
        end else begin
          chk("lsu_rsp_rdata", bus.lsu_rsp_rdata, exp_lsu_q.pop_front());
        end
      end
      if (bus.vpu_rsp_valid && bus.vpu_rsp_ready) begin
        if (exp_vpu_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL vpu_rsp_unexpected: got 0x%0h expected no response", bus.vpu_rsp_rdata);
        end else begin
          chk("vpu_rsp_rdata", bus.vpu_rsp_rdata, exp_vpu_q.pop_front());
        end
      end
      if (bus.lsu_rsp_fencei_over) fence_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr_req();
    bus.lsu_req_valid = 0; bus.lsu_req_ren = 0; bus.lsu_req_wen = 0; bus.lsu_req_fencei = 0;
    bus.lsu_req_addr = 0; bus.lsu_req_wdata = 0;
    bus.vpu_req_valid = 0; bus.vpu_req_ren = 0; bus.vpu_req_wen = 0;
    bus.vpu_req_addr = 0; bus.vpu_req_wdata = 0;
    bus.mem_req_ready = 0;
    flush_req = 0;
  endtask

  // Present one request, wait (bounded) for its grant, complete the handshake.
  // Returns at posedge+1 of the first cycle in the wait state.
  task automatic issue(input bit is_vpu, input logic ren, input logic wen, input logic f,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    if (is_vpu) begin
      bus.vpu_req_ren = ren; bus.vpu_req_wen = wen;
      bus.vpu_req_addr = addr; bus.vpu_req_wdata = wd; bus.vpu_req_valid = 1;
    end else begin
      bus.lsu_req_ren = ren; bus.lsu_req_wen = wen; bus.lsu_req_fencei = f;
      bus.lsu_req_addr = addr; bus.lsu_req_wdata = wd; bus.lsu_req_valid = 1;
    end
    bus.mem_req_ready = 1;
    #1;
    n = 0;
    while (((is_vpu ? bus.vpu_req_ready : bus.lsu_req_ready) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    chk(is_vpu ? "vpu_accept" : "lsu_accept",
        32'(is_vpu ? bus.vpu_req_ready : bus.lsu_req_ready), 32'd1);
    tick();
    clr_req();
  endtask

  task automatic respond(input logic [31:0] rd);
    bus.mem_rsp_valid = 1;
    bus.mem_rsp_rdata = rd;
    tick();
    bus.mem_rsp_valid = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    #12;
    @(negedge clock);
    reset = 1;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        fl, lv, lren, lwen, lf;
    logic [31:0] la, lwd;
    logic        vv, vren, vwen;
    logic [31:0] va, vwd;
    logic        mrdy;
    logic        e_mrv, e_chk, e_ren, e_wen, e_f;
    logic [31:0] e_addr, e_wd;
    logic [2:0]  e_flag;
    logic        e_lr, e_vr;
  } vec_t;

  function automatic vec_t mk(input string n, input logic fl, lv, lren, lwen, lf,
                              input logic [31:0] la, lwd, input logic vv, vren, vwen,
                              input logic [31:0] va, vwd, input logic mrdy,
                              input logic emrv, echk, eren, ewen, ef,
                              input logic [31:0] ea, ewd, input logic [2:0] efl,
                              input logic elr, evr);
    vec_t v;
    v.name = n; v.fl = fl; v.lv = lv; v.lren = lren; v.lwen = lwen; v.lf = lf;
    v.la = la; v.lwd = lwd; v.vv = vv; v.vren = vren; v.vwen = vwen; v.va = va; v.vwd = vwd;
    v.mrdy = mrdy; v.e_mrv = emrv; v.e_chk = echk; v.e_ren = eren; v.e_wen = ewen; v.e_f = ef;
    v.e_addr = ea; v.e_wd = ewd; v.e_flag = efl; v.e_lr = elr; v.e_vr = evr;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    logic exp_v;
    logic gv;
    int   n;

    vecs[0] = mk("lsu_rd", 0, 1,1,0,0, 32'h8000_0010, 32'h0, 0,0,0, 32'h0, 32'h0, 1,
                 1,1,1,0,0, 32'h8000_0010, 32'h0, 3'b010, 1,0);
    vecs[1] = mk("lsu_wr_stall", 0, 1,0,1,0, 32'h1000_0004, 32'h1234_5678, 0,0,0, 32'h0, 32'h0, 0,
                 1,1,0,1,0, 32'h1000_0004, 32'h1234_5678, 3'b010, 0,0);
    vecs[2] = mk("vpu_wr", 0, 0,0,0,1, 32'h0, 32'h0, 1,0,1, 32'h2000_0008, 32'hCAFE_F00D, 1,
                 1,1,0,1,0, 32'h2000_0008, 32'hCAFE_F00D, 3'b101, 0,1);
    vecs[3] = mk("both_lsu_wins", 0, 1,1,0,0, 32'h3000_0000, 32'h0, 1,1,0, 32'h4000_0000, 32'h0, 1,
                 1,1,1,0,0, 32'h3000_0000, 32'h0, 3'b010, 1,0);
    vecs[4] = mk("flush_both", 1, 1,1,0,0, 32'h3000_0000, 32'h0, 1,1,0, 32'h4000_0000, 32'h0, 1,
                 0,0,0,0,0, 32'h0, 32'h0, 3'b000, 0,0);
    vecs[5] = mk("lsu_fence", 0, 1,0,0,1, 32'h0000_0040, 32'h0, 0,0,0, 32'h0, 32'h0, 1,
                 1,1,0,0,1, 32'h0000_0040, 32'h0, 3'b010, 1,0);
    vecs[6] = mk("idle_none", 0, 0,0,0,0, 32'h0, 32'h0, 0,0,0, 32'h0, 32'h0, 0,
                 0,0,0,0,0, 32'h0, 32'h0, 3'b000, 0,0);
    vecs[7] = mk("flush_vpu", 1, 0,0,0,0, 32'h0, 32'h0, 1,1,0, 32'h5000_0000, 32'h0, 1,
                 0,0,0,0,0, 32'h0, 32'h0, 3'b000, 0,0);

    // ---- reset state (response inputs active to prove outputs stay low) ----
    reset = 0;
    clr_req();
    bus.lsu_req_flag = 3'b010;
    bus.vpu_req_flag = 3'b101;
    bus.lsu_rsp_ready = 1;
    bus.vpu_rsp_ready = 1;
    bus.mem_rsp_valid = 1;
    bus.mem_rsp_fencei_over = 1;
    bus.mem_rsp_rdata = 32'h0;
    #3;
    chk("rst_busy",        32'(arb_o_busy), 32'd0);
    chk("rst_state",       32'(dbg_state), 32'd0);
    chk("rst_mem_rsp_rdy", 32'(bus.mem_rsp_ready), 32'd0);
    chk("rst_lsu_rsp_vld", 32'(bus.lsu_rsp_valid), 32'd0);
    chk("rst_vpu_rsp_vld", 32'(bus.vpu_rsp_valid), 32'd0);
    chk("rst_fencei_over", 32'(bus.lsu_rsp_fencei_over), 32'd0);
    bus.mem_rsp_valid = 0;
    bus.mem_rsp_fencei_over = 0;
    #20;
    @(negedge clock);
    reset = 1;
    tick();

    // ---- combinational grant table (never crosses an edge with valid high) ----
    for (int i = 0; i < 8; i++) begin
      flush_req = vecs[i].fl;
      bus.lsu_req_valid = vecs[i].lv; bus.lsu_req_ren = vecs[i].lren;
      bus.lsu_req_wen = vecs[i].lwen; bus.lsu_req_fencei = vecs[i].lf;
      bus.lsu_req_addr = vecs[i].la; bus.lsu_req_wdata = vecs[i].lwd;
      bus.vpu_req_valid = vecs[i].vv; bus.vpu_req_ren = vecs[i].vren;
      bus.vpu_req_wen = vecs[i].vwen; bus.vpu_req_addr = vecs[i].va;
      bus.vpu_req_wdata = vecs[i].vwd; bus.mem_req_ready = vecs[i].mrdy;
      #1;
      chk({vecs[i].name, "/mem_req_valid"}, 32'(bus.mem_req_valid), 32'(vecs[i].e_mrv));
      chk({vecs[i].name, "/lsu_req_ready"}, 32'(bus.lsu_req_ready), 32'(vecs[i].e_lr));
      chk({vecs[i].name, "/vpu_req_ready"}, 32'(bus.vpu_req_ready), 32'(vecs[i].e_vr));
      if (vecs[i].e_chk) begin
        chk({vecs[i].name, "/addr"},   bus.mem_req_addr, vecs[i].e_addr);
        chk({vecs[i].name, "/wdata"},  bus.mem_req_wdata, vecs[i].e_wd);
        chk({vecs[i].name, "/ren"},    32'(bus.mem_req_ren), 32'(vecs[i].e_ren));
        chk({vecs[i].name, "/wen"},    32'(bus.mem_req_wen), 32'(vecs[i].e_wen));
        chk({vecs[i].name, "/fencei"}, 32'(bus.mem_req_fencei), 32'(vecs[i].e_f));
        chk({vecs[i].name, "/flag"},   32'(bus.mem_req_flag), 32'(vecs[i].e_flag));
      end
      clr_req();
      tick();
    end

    // ---- LSU read, response 3 cycles after acceptance ----
    exp_lsu_q.push_back(32'hDEAD_BEEF);
    issue(0, 1, 0, 0, 32'h8000_0010, 32'h0);
    #1;
    chk("rd_state_wait_lsu", 32'(dbg_state), 32'd1);
    chk("rd_busy",           32'(arb_o_busy), 32'd1);
    bus.mem_req_ready = 1;
    bus.lsu_req_valid = 1;
    #1;
    chk("rd_no_req_in_wait", 32'(bus.mem_req_valid), 32'd0);
    chk("rd_no_ready_in_wait", 32'(bus.lsu_req_ready), 32'd0);
    clr_req();
    tick();
    tick();
    bus.mem_rsp_valid = 1;
    bus.mem_rsp_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd1);
    chk("rd_vpu_rsp_valid", 32'(bus.vpu_rsp_valid), 32'd0);
    chk("rd_mem_rsp_ready", 32'(bus.mem_rsp_ready), 32'd1);
    tick();
    bus.mem_rsp_valid = 0;
    #1;
    chk("rd_back_idle", 32'(dbg_state), 32'd0);

    // ---- response back-pressure from the LSU ----
    exp_lsu_q.push_back(32'h1111_2222);
    issue(0, 0, 1, 0, 32'h0000_1000, 32'hAAAA_5555);
    bus.mem_rsp_valid = 1;
    bus.mem_rsp_rdata = 32'h1111_2222;
    bus.lsu_rsp_ready = 0;
    #1;
    chk("bp_lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd1);
    chk("bp_mem_rsp_ready", 32'(bus.mem_rsp_ready), 32'd0);
    tick();
    chk("bp_hold_state", 32'(dbg_state), 32'd1);
    bus.lsu_rsp_ready = 1;
    #1;
    chk("bp_mem_rsp_ready_go", 32'(bus.mem_rsp_ready), 32'd1);
    tick();
    bus.mem_rsp_valid = 0;
    #1;
    chk("bp_back_idle", 32'(dbg_state), 32'd0);

    // ---- flush and response in the same WAIT_LSU cycle ----
    issue(0, 1, 0, 0, 32'h0000_2000, 32'h0);
    flush_req = 1;
    bus.mem_rsp_valid = 1;
    bus.mem_rsp_rdata = 32'h5555_5555;
    #1;
    chk("fr_mem_rsp_ready", 32'(bus.mem_rsp_ready), 32'd1);
    chk("fr_lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd0);
    tick();
    flush_req = 0;
    bus.mem_rsp_valid = 0;
    #1;
    chk("fr_idle", 32'(dbg_state), 32'd0);

    // ---- VPU read flushed, response arrives later through DRAIN ----
    issue(1, 1, 0, 0, 32'h0000_3000, 32'h0);
    chk("dr_wait_vpu", 32'(dbg_state), 32'd2);
    flush_req = 1;
    tick();
    flush_req = 0;
    #1;
    chk("dr_state_drain", 32'(dbg_state), 32'd4);
    chk("dr_busy",        32'(arb_o_busy), 32'd1);
    chk("dr_mem_rsp_rdy", 32'(bus.mem_rsp_ready), 32'd1);
    tick();
    bus.mem_rsp_valid = 1;
    bus.mem_rsp_rdata = 32'h7777_7777;
    #1;
    chk("dr_vpu_rsp_valid", 32'(bus.vpu_rsp_valid), 32'd0);
    chk("dr_mem_rsp_ready", 32'(bus.mem_rsp_ready), 32'd1);
    tick();
    bus.mem_rsp_valid = 0;
    #1;
    chk("dr_idle", 32'(dbg_state), 32'd0);

    // ---- fence.i ignores flush and ends on the fencei_over pulse ----
    fence_cnt = 0;
    issue(0, 0, 0, 1, 32'h0, 32'h0);
    chk("fe_state", 32'(dbg_state), 32'd3);
    flush_req = 1;
    tick();
    flush_req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fe_hold_state", 32'(dbg_state), 32'd3);
      tick();
    end
    bus.mem_rsp_fencei_over = 1;
    #1;
    chk("fe_over_pulse", 32'(bus.lsu_rsp_fencei_over), 32'd1);
    tick();
    bus.mem_rsp_fencei_over = 0;
    #1;
    chk("fe_idle", 32'(dbg_state), 32'd0);
    chk("fe_over_low", 32'(bus.lsu_rsp_fencei_over), 32'd0);
    chk("fe_pulse_count", 32'(fence_cnt), 32'd1);

    // ---- asynchronous reset during WAIT_VPU ----
    issue(1, 1, 0, 0, 32'h0000_4000, 32'h0);
    bus.mem_rsp_valid = 1;
    bus.vpu_rsp_ready = 0;
    #1;
    chk("ar_vpu_rsp_valid_pre", 32'(bus.vpu_rsp_valid), 32'd1);
    #1;
    reset = 0;
    #1;
    chk("ar_busy",          32'(arb_o_busy), 32'd0);
    chk("ar_vpu_rsp_valid", 32'(bus.vpu_rsp_valid), 32'd0);
    chk("ar_state",         32'(dbg_state), 32'd0);
    bus.mem_rsp_valid = 0;
    bus.vpu_rsp_ready = 1;
    @(negedge clock);
    reset = 1;
    tick();

    // ---- simultaneous requests for 4 grants (pointer fresh from reset) ----
    bus.lsu_req_valid = 1; bus.lsu_req_ren = 1; bus.lsu_req_addr = 32'h0000_A000;
    bus.vpu_req_valid = 1; bus.vpu_req_ren = 1; bus.vpu_req_addr = 32'h0000_B000;
    bus.mem_req_ready = 1;
    for (int g = 0; g < 4; g++) begin
      #1;
      n = 0;
      while (!(bus.lsu_req_ready || bus.vpu_req_ready) && n < 20) begin
        tick();
        n++;
      end
`ifdef LIEAT_DCACHE_ARB_RR_EN
      exp_v = (g % 2) == 1;
`else
      exp_v = 1'b0;
`endif
      gv = bus.vpu_req_ready;
      chk("rr_grant_is_vpu", 32'(gv), 32'(exp_v));
      chk("rr_grant_any", 32'(bus.lsu_req_ready | bus.vpu_req_ready), 32'd1);
      chk("rr_addr", bus.mem_req_addr, exp_v ? 32'h0000_B000 : 32'h0000_A000);
      if (gv) exp_vpu_q.push_back(32'hA0 + 32'(g));
      else    exp_lsu_q.push_back(32'hA0 + 32'(g));
      tick();
      chk("rr_no_ready_in_wait", 32'(bus.lsu_req_ready | bus.vpu_req_ready), 32'd0);
      respond(32'hA0 + 32'(g));
    end
    clr_req();
    tick();

    // ---- ungranted VPU holds valid and is served exactly once ----
    do_reset();
    bus.lsu_req_valid = 1; bus.lsu_req_ren = 1; bus.lsu_req_addr = 32'h0000_C000;
    bus.vpu_req_valid = 1; bus.vpu_req_wen = 1; bus.vpu_req_addr = 32'h0000_D000;
    bus.vpu_req_wdata = 32'h1357_9BDF;
    bus.mem_req_ready = 1;
    #1;
    chk("hold_lsu_first", 32'(bus.lsu_req_ready), 32'd1);
    chk("hold_vpu_waits", 32'(bus.vpu_req_ready), 32'd0);
    exp_lsu_q.push_back(32'hC0C0_C0C0);
    tick();
    bus.lsu_req_valid = 0;
    respond(32'hC0C0_C0C0);
    #1;
    chk("hold_vpu_granted", 32'(bus.vpu_req_ready), 32'd1);
    chk("hold_vpu_addr",    bus.mem_req_addr, 32'h0000_D000);
    chk("hold_vpu_wdata",   bus.mem_req_wdata, 32'h1357_9BDF);
    exp_vpu_q.push_back(32'hD0D0_D0D0);
    tick();
    bus.vpu_req_valid = 0;
    respond(32'hD0D0_D0D0);
    #1;
    chk("hold_idle",       32'(dbg_state), 32'd0);
    chk("hold_no_dup_req", 32'(bus.mem_req_valid), 32'd0);
    clr_req();
    tick();

    // ---- scoreboard drained ----
    chk("lsu_q_empty", 32'(exp_lsu_q.size()), 32'd0);
    chk("vpu_q_empty", 32'(exp_vpu_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lieat_exu_dcache_arb.md
LIEAT_EXU_DCACHE_ARB -- requirements
Module: lieat_exu_dcache_arb

Interface
REQ-001 Parameter XLEN, default 32, SHALL set address and data width.
REQ-002 clock  input  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 flush_req  input  1  SHALL be the pipeline flush from the commit unit.
REQ-005 lsu_req_valid/ready/ren/wen/fencei  in/out/in/in/in  1 each  SHALL be the LSU request handshake, read enable, write enable and fence.i flag.
REQ-006 lsu_req_addr/wdata  input  XLEN each; lsu_req_flag  input  3  SHALL carry the LSU address, store data and size/sign flag.
REQ-007 lsu_rsp_valid/ready/fencei_over  out/in/out  1 each; lsu_rsp_rdata  output  XLEN  SHALL return the LSU response.
REQ-008 vpu_req_valid/ready/ren/wen  in/out/in/in  1 each; vpu_req_addr/wdata  input  XLEN; vpu_req_flag  input  3  SHALL be the VPU request port.
REQ-009 vpu_rsp_valid/ready  out/in  1 each; vpu_rsp_rdata  output  XLEN  SHALL return the VPU response.
REQ-010 mem_req_* (valid out, ready in, ren/wen/fencei/addr/flag/wdata out)  SHALL drive the single dcache request port.
REQ-011 mem_rsp_valid/fencei_over  input  1; mem_rsp_ready  output  1; mem_rsp_rdata  input  XLEN  SHALL be the dcache response port.
REQ-012 arb_o_busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, WAIT_LSU, WAIT_VPU, WAIT_FENCE and DRAIN, with at most one outstanding transaction.
REQ-014 Every read or write request SHALL produce exactly one mem_rsp_valid/mem_rsp_ready handshake; a fence.i request SHALL complete on a one-cycle mem_rsp_fencei_over pulse.
REQ-015 In IDLE with flush_req low, the arbiter SHALL grant one requester combinationally, set mem_req_valid to that requester's valid, and drive mem_req_* from its fields (mem_req_fencei=0 for VPU).
REQ-016 The granted requester's req_ready SHALL equal mem_req_ready; the non-granted requester's req_ready SHALL be 0, and both SHALL be 0 outside IDLE.
REQ-017 On a request handshake the FSM SHALL move to WAIT_FENCE (LSU with fencei=1), WAIT_LSU (other LSU requests) or WAIT_VPU, so requests SHALL be accepted with zero added latency.
REQ-018 In WAIT_LSU/WAIT_VPU the owner's rsp_valid SHALL equal mem_rsp_valid, rsp_rdata SHALL equal mem_rsp_rdata, mem_rsp_ready SHALL equal the owner's rsp_ready, the other rsp_valid SHALL be 0, and a handshake SHALL return the FSM to IDLE.
REQ-019 In WAIT_FENCE lsu_rsp_fencei_over SHALL equal mem_rsp_fencei_over, the FSM SHALL return to IDLE on that pulse, and flush_req SHALL be ignored.
REQ-020 flush_req high in WAIT_LSU/WAIT_VPU SHALL take priority over the response: if mem_rsp_valid is high in that cycle, the response SHALL be consumed (mem_rsp_ready=1), not forwarded, and the FSM SHALL go to IDLE; otherwise the FSM SHALL go to DRAIN.
REQ-021 In DRAIN mem_rsp_ready SHALL be 1, both rsp_valid outputs SHALL be 0, and the FSM SHALL go to IDLE on mem_rsp_valid.
REQ-022 flush_req high in IDLE SHALL force mem_req_valid and both req_ready outputs to 0 for that cycle.
REQ-023 A requester SHALL be able to hold valid across cycles while ungranted with no loss or duplication of its request.

Reset
REQ-024 While reset is low the FSM SHALL be IDLE, the round-robin pointer SHALL favour LSU, and arb_o_busy, all rsp_valid, fencei_over and mem_rsp_ready outputs SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction; the response to an abandoned transaction is the dcache's responsibility.

Configuration
REQ-026 With LIEAT_DCACHE_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not granted last, and the pointer SHALL update on each request handshake.
REQ-027 Without LIEAT_DCACHE_ARB_RR_EN, LSU SHALL always win simultaneous requests and no pointer state SHALL exist.

Verification
REQ-028 LSU read addr 0x8000_0010, mem_req_ready=1, mem_rsp rdata 0xDEAD_BEEF after 3 cycles -> lsu_rsp_valid with 0xDEAD_BEEF, vpu_rsp_valid stays 0, FSM back in IDLE.
REQ-029 LSU and VPU valid together every cycle for 4 grants, RR enabled -> grant order LSU,VPU,LSU,VPU; RR disabled -> LSU,LSU,LSU,LSU.
REQ-030 VPU read outstanding, flush_req pulsed for 1 cycle, mem_rsp_valid 2 cycles later -> FSM enters DRAIN, vpu_rsp_valid never rises, IDLE follows the response.
REQ-031 LSU fence.i accepted, flush_req pulsed, mem_rsp_fencei_over 5 cycles later -> lsu_rsp_fencei_over pulses once, state stays WAIT_FENCE until the pulse.
REQ-032 Flush and mem_rsp_valid in the same WAIT_LSU cycle -> mem_rsp_ready=1, lsu_rsp_valid=0, FSM in IDLE next cycle.
REQ-033 reset driven low during WAIT_VPU -> arb_o_busy=0 and vpu_rsp_valid=0 immediately, without waiting for a clock edge.
